// File: rtl/niosii_sys_key_debounce.sv
// Two-flop synchronizer plus per-bit debouncer for active-low push-buttons.
// Optional one-cycle press pulses are enabled with the KEY_DEBOUNCE_PRESS_EN macro.
module niosii_sys_key_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] key_out,
    output logic [WIDTH-1:0] key_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    state_e           w_state   [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_accept;

    // Per-bit state is implied by whether the synchronized level disagrees with the accepted one.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_cnt_nxt[i] = '0;
            w_state[i]   = (r_s2[i] != r_stable[i]) ? COUNT : IDLE;
            case (w_state[i])
                IDLE: w_cnt_nxt[i] = '0;
                COUNT: begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_accept[i]  = 1'b1;
                        w_cnt_nxt[i] = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: w_cnt_nxt[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= {WIDTH{RESET_LEVEL}};
            r_s2     <= {WIDTH{RESET_LEVEL}};
            r_stable <= {WIDTH{RESET_LEVEL}};
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1     <= key_in;
            r_s2     <= r_s1;
            r_stable <= (r_stable & ~w_accept) | (r_s2 & w_accept);
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign key_out = r_stable;

`ifdef KEY_DEBOUNCE_PRESS_EN
    logic [WIDTH-1:0] r_press;

    // A press is an accepted transition to 0; pulse lines up with the key_out fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press <= '0;
        end else begin
            r_press <= w_accept & ~r_s2;
        end
    end

    assign key_press = r_press;
`else
    assign key_press = '0;
`endif

endmodule
